// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for T-FF bank controllers: state encoding and
// count-direction constants.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/tff_count_ctrl_if.sv
// Host command / bank loopback bundle for tff_count_ctrl. The master side
// drives commands and the bank's q; the slave side is the controller.
interface tff_count_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             up;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] t_en;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, up, limit, q_in,
        input  t_en, busy, done
    );

    modport slave (
        input  start, stop, up, limit, q_in,
        output t_en, busy, done
    );
endinterface

// File: rtl/tff_toggle_gen.sv
// Combinational toggle vector for a T-FF counter: bit i toggles when all
// lower bits are 1 (up) or all lower bits are 0 (down).
module tff_toggle_gen
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q_in,
    input  logic             dir,
    output logic [WIDTH-1:0] t_vec
);
    logic [WIDTH-1:0] carry_bits;
    logic             run;

    assign carry_bits = (dir == DIR_UP) ? q_in : ~q_in;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        t_vec = '0;
        run   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            t_vec[i] = run;
            run      = run & carry_bits[i];
        end
    end
endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencing controller for an external T-FF bank: clear, count to limit,
// pulse done. Define TFF_COUNT_CTRL_WRAP_EN for free-running (DONE -> CLEAR).
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rest,
    tff_count_ctrl_if.slave   bus
);
    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] step_vec;
    logic [WIDTH-1:0] t_en_c;

    tff_toggle_gen #(.WIDTH(WIDTH)) u_toggle_gen (
        .q_in  (bus.q_in),
        .dir   (dir_q),
        .t_vec (step_vec)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        limit_d = limit_q;
        t_en_c  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dir_d   = bus.up;
                    limit_d = bus.limit;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                // Toggling every set bit drives the bank to zero from any value.
                t_en_c  = bus.q_in;
                state_d = COUNT;
            end
            COUNT: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.q_in == limit_q) begin
                    state_d = DONE;
                end else begin
                    t_en_c  = step_vec;
                end
            end
            DONE: begin
`ifdef TFF_COUNT_CTRL_WRAP_EN
                state_d = bus.stop ? IDLE : CLEAR;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q <= IDLE;
            dir_q   <= DIR_DOWN;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            limit_q <= limit_d;
        end
    end

    assign bus.t_en = t_en_c;
    assign bus.busy = (state_q == CLEAR) || (state_q == COUNT);
    assign bus.done = (state_q == DONE);
endmodule
